uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_receiver.sv | 170 +++++++++++++++++
 tb/tb_uart_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state encodings, the receive
// FIFO depth and a helper that sizes the bit timer.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;

    // Smallest timer width that can hold div-1 (at least one bit).
    function automatic int unsigned timer_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO (FIFO_DEPTH entries, first-in first-out). Head entry is
// presented on o_data. A push while full is accepted only when a pop
// happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_data
);

    localparam logic [FIFO_PTR_W-1:0] PTR_ONE   = FIFO_PTR_W'(1);
    localparam logic [FIFO_PTR_W:0]   CNT_ONE   = (FIFO_PTR_W + 1)'(1);
    localparam logic [FIFO_PTR_W:0]   CNT_DEPTH = (FIFO_PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_PTR_W:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_DEPTH);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointer and occupancy update; pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first, centre sampling with a DIV-cycle bit timer.
// Received bytes go to a single holding register by default, or to a
// 4-entry FIFO (uart_rx_fifo) when UART_RX_FIFO_EN is defined.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 16_000_000,
    parameter int unsigned baud_rate   = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned DIV  = clk_freq_hz / baud_rate;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned TW   = timer_width(DIV);

    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [1:0]    r_settle;
    logic          r_armed;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_frame_err;
    logic          r_overrun;

    logic          w_expired;
    logic          w_push;
    logic          w_stop_bad;
    logic          w_pop;
    logic          w_full;

    assign w_expired  = (r_timer == '0);
    assign w_push     = (r_state == ST_STOP) & w_expired & r_rx_s;
    assign w_stop_bad = (r_state == ST_STOP) & w_expired & ~r_rx_s;
    assign w_pop      = o_valid & i_ready;

    // Two-flop synchronizer; r_settle marks when reset values have been flushed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_settle  <= '0;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_settle  <= {r_settle[0], 1'b1};
        end
    end

    // Frame FSM: start detect, centre-sampled data bits, stop-bit check.
    // Arming waits for r_settle so the synchronizer's reset-high values are
    // never mistaken for an idle line after a reset with the line held low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_armed   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_s && r_settle[1]) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && !r_rx_s) begin
                        r_state <= ST_START;
                        r_timer <= T_HALF;
                    end
                end
                ST_START: begin
                    if (!w_expired) begin
                        r_timer <= r_timer - T_ONE;
                    end else if (!r_rx_s) begin
                        r_state   <= ST_DATA;
                        r_timer   <= T_FULL;
                        r_bit_idx <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_expired) begin
                        r_timer <= r_timer - T_ONE;
                    end else begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_timer   <= T_FULL;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!w_expired) begin
                        r_timer <= r_timer - T_ONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle status pulses, registered after the stop-bit sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_push & w_full & ~w_pop;
        end
    end

    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

`ifdef UART_RX_FIFO_EN
    logic w_empty;

    uart_rx_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (o_data)
    );

    assign o_valid = ~w_empty;
`else
    logic [7:0] r_hold;
    logic       r_hold_valid;

    // Single holding register; a push while full is taken only alongside a pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_push && (!r_hold_valid || w_pop)) begin
            r_hold       <= r_shift;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_full  = r_hold_valid;
    assign o_valid = r_hold_valid;
    assign o_data  = r_hold;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (16 MHz clock, 1 Mbaud, 16 cycles/bit).
// Expected bytes come from a capacity-limited queue model of the buffer.
module tb_uart_receiver;

    localparam int BIT = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;

    uart_receiver #(
        .clk_freq_hz (16_000_000),
        .baud_rate   (1_000_000)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (ferr),
        .o_overrun   (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         valid_cycles = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         first_valid = -1;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Observe handshakes, pulses and data stability on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && valid) chk("hold_stable", data, prev_data);
            prev_hold = valid && !ready;
            prev_data = data;
            if (valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
                if (ready) rx_q.push_back(data);
            end
            if (ferr) ferr_cnt++;
            if (ovr) ovr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clear_obs();
        rx_q.delete();
        valid_cycles = 0;
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        first_valid  = -1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (BIT) tick();
        end
        rx = 1'b1;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall;
        int ovr_exp;
        logic [7:0] b;

        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", valid, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_data", data, 8'h00);
        rst = 1'b0;
        idle(20);

        // Single byte, latency and single-cycle valid with ready high
        clear_obs();
        exp_q = '{8'h55};
        fall = cyc;
        send_frame(8'h55, 1'b1);
        idle(20);
        check_rx("t55");
        chk_range("t55_latency", first_valid - fall, 150, 156);
        chk("t55_valid_cycles", valid_cycles, 1);
        chk("t55_ferr", ferr_cnt, 0);
        chk("t55_ovr", ovr_cnt, 0);

        // Short low glitch is not a start bit
        clear_obs();
        rx = 1'b0;
        repeat (4) tick();
        idle(200);
        chk("glitch_valid", valid_cycles, 0);
        chk("glitch_ferr", ferr_cnt, 0);

        // Bad stop bit, then a good frame
        clear_obs();
        send_frame(8'hA3, 1'b0);
        idle(40);
        chk("ferr_pulses", ferr_cnt, 1);
        chk("ferr_valid", valid_cycles, 0);
        clear_obs();
        exp_q = '{8'h3C};
        send_frame(8'h3C, 1'b1);
        idle(20);
        check_rx("after_ferr");
        chk("after_ferr_ferr", ferr_cnt, 0);

        // Overrun with consumer stalled: buffer holds CAP bytes
        ready = 1'b0;
        clear_obs();
        exp_q.delete();
        ovr_exp = 0;
        for (int k = 1; k <= CAP + 1; k++) begin
            b = 8'(k);
            if (exp_q.size() < CAP) exp_q.push_back(b);
            else ovr_exp++;
            send_frame(b, 1'b1);
            idle(10);
        end
        chk("ovr_pulses", ovr_cnt, ovr_exp);
        chk("ovr_no_transfer", rx_q.size(), 0);
        chk("ovr_head", data, exp_q[0]);
        chk("ovr_valid", valid, 1);
        ready = 1'b1;
        idle(10);
        check_rx("ovr_drain");
        chk("ovr_drained_valid", valid, 0);

        // Reset mid-byte with the line low
        clear_obs();
        rx = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        idle(40);
        chk("midrst_valid", valid_cycles, 0);
        chk("midrst_ferr", ferr_cnt, 0);
        clear_obs();
        exp_q = '{8'h3C};
        send_frame(8'h3C, 1'b1);
        idle(20);
        check_rx("midrst");
        chk("midrst_ferr2", ferr_cnt, 0);

        // Back-to-back frames with no idle gap
        clear_obs();
        exp_q = '{8'h00, 8'hFF};
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check_rx("b2b");
        chk("b2b_ferr", ferr_cnt, 0);
        chk("b2b_ovr", ovr_cnt, 0);

        // Random bytes with random gaps (including zero)
        clear_obs();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle(int'($urandom_range(0, 24)));
        end
        idle(20);
        check_rx("rand");
        chk("rand_ferr", ferr_cnt, 0);
        chk("rand_ovr", ovr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
